// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared encodings for the radix-3 shift sequencer
package shift_sequencer_pkg;
  localparam int WIDTH = 16;

  localparam logic [1:0] MODE_SLL  = 2'b00;
  localparam logic [1:0] MODE_SRA  = 2'b01;
  localparam logic [1:0] MODE_ROR  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ONES   = 3'd1;
  localparam state_t ST_THREES = 3'd2;
  localparam state_t ST_NINES  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam logic [3:0] W_ONES   = 4'd1;
  localparam logic [3:0] W_THREES = 4'd3;
  localparam logic [3:0] W_NINES  = 4'd9;
endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/response bundle of the shift sequencer
interface shift_sequencer_if;
  import shift_sequencer_pkg::*;

  logic             start;
  logic [1:0]       mode;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, output mode, output shamt, output data_in,
                  input busy, input done, input result);
  modport slave  (input start, input mode, input shamt, input data_in,
                  output busy, output done, output result);
endinterface

// File: rtl/shift_sequencer_stage.sv
// rtl/shift_sequencer_stage.sv - one weighted shift stage, shared across all digits
module shift_stage
  import shift_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       digit_i,
  input  logic [3:0]       weight_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] value_o
);
  logic [5:0]         k;
  logic [2*WIDTH-1:0] rot;

  assign k = {4'b0, digit_i} * {2'b0, weight_i};

  always_comb begin
    // Rotation via the doubled word: the low half is the rotated value.
    rot = {value_i, value_i} >> k;
    case (mode_i)
      MODE_SLL: value_o = value_i << k;
      MODE_SRA: value_o = $signed(value_i) >>> k;
      MODE_ROR: value_o = rot[WIDTH-1:0];
      default:  value_o = value_i;
    endcase
  end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - three-cycle radix-3 shift controller around one shared stage
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       d1_q, d1_d, d3_q, d3_d, d9_q, d9_d;
  logic [1:0]       digit;
  logic [3:0]       weight;
  logic [WIDTH-1:0] stage_out;
  logic             accept;

  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    digit  = 2'd0;
    weight = W_ONES;
    case (state_q)
      ST_ONES:   begin digit = d1_q; weight = W_ONES;   end
      ST_THREES: begin digit = d3_q; weight = W_THREES; end
      ST_NINES:  begin digit = d9_q; weight = W_NINES;  end
      default:   begin digit = 2'd0; weight = W_ONES;   end
    endcase
  end

  shift_stage u_stage (
    .value_i  (work_q),
    .digit_i  (digit),
    .weight_i (weight),
    .mode_i   (mode_q),
    .value_o  (stage_out)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    mode_d   = mode_q;
    d1_d     = d1_q;
    d3_d     = d3_q;
    d9_d     = d9_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          work_d  = bus.data_in;
          mode_d  = bus.mode;
          d1_d    = 2'(bus.shamt % 4'd3);
          d3_d    = 2'((bus.shamt / 4'd3) % 4'd3);
          d9_d    = 2'(bus.shamt / 4'd9);
          state_d = ST_ONES;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ONES: begin
        work_d  = stage_out;
        state_d = ST_THREES;
      end
      ST_THREES: begin
        work_d  = stage_out;
        state_d = ST_NINES;
      end
      ST_NINES: begin
        work_d   = stage_out;
        result_d = stage_out;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      result_q <= '0;
      mode_q   <= MODE_SLL;
      d1_q     <= 2'd0;
      d3_q     <= 2'd0;
      d9_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      d1_q     <= d1_d;
      d3_q     <= d3_d;
      d9_q     <= d9_d;
    end
  end

  assign bus.busy   = (state_q == ST_ONES) || (state_q == ST_THREES) || (state_q == ST_NINES);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the radix-3 barrel shifter in the execute stage. It accepts one shift request (SLL, SRA or ROR, 4-bit amount), splits the amount into base-3 digits (ones, threes, nines), and drives one shared shift stage once per digit over three cycles. It returns the result with a one-cycle done pulse. It lets the ALU replace the full single-cycle 16-bit shifter with a single weighted stage.

## Interface
- WIDTH, 16, data width; shamt is fixed at 4 bits (0..15), so every shift is smaller than WIDTH
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request strobe; accepted only when busy=0
- mode  in  2  00=SLL, 01=SRA, 10=ROR, 11=pass-through (no shift)
- shamt  in  4  shift amount, unsigned
- data_in  in  WIDTH  operand
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse when result is updated
- result  out  WIDTH  last completed result; held until the next completion

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, ONES, THREES, NINES, DONE.
- IDLE or DONE with start=1 at a rising edge:
  - latch data_in into the work register
  - latch mode
  - latch digits: d1 = shamt mod 3, d3 = (shamt/3) mod 3, d9 = shamt/9 (d9 is 0 or 1)
  - go to ONES
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- ONES: work register ← shift by d1×1, then go to THREES.
- THREES: work register ← shift by d3×3, then go to NINES.
- NINES: shift by d9×9, load the value into both the work register and result, then go to DONE.
- Shift rules per stage (amount k = digit×weight, 0..18, but never above 15 in total):
  - SLL: zero-fill from the LSB.
  - SRA: replicate bit WIDTH-1.
  - ROR: rotate right.
  - k = 0 leaves the value unchanged.
- mode=11: every stage passes the value through unchanged, so result = data_in.
- Stages are never skipped. A zero digit still takes its cycle, so latency is fixed.
- start while busy=1 is ignored. It is neither queued nor does it disturb the operation in flight.
- Inputs are sampled only on the accept edge. Later changes to data_in, mode or shamt have no effect on the operation in flight.

## Timing
- Reset values: state=IDLE; busy=0, done=0, result=0; work register and digits are 0.
- Reset is asynchronous. rst_n low at any point, including mid-operation, forces the reset values immediately, and the in-flight request is lost.
- Let E0 be the accept edge.
  - busy rises after E0 and stays high through the states ONES, THREES and NINES.
  - result updates and done=1 after edge E3, in the DONE state, for exactly one cycle.
  - busy=0 in DONE.
- Latency: result is visible 3 clock cycles after the accept edge.
- Back-to-back: start=1 in the DONE cycle is accepted at E4.
  - The next state is ONES, and done falls after E4.
  - result keeps its value until E7.
  - Throughput is one shift per 4 cycles when back-to-back; idle cycles between requests are allowed.
- busy and done are registered outputs (decoded from state flops), so there are no combinational paths from the inputs.

## Structure
- Shared package holds:
  - mode encodings: MODE_SLL, MODE_SRA, MODE_ROR, MODE_PASS
  - state enum
  - stage weights: 1, 3, 9
- Sub-module shift_stage (combinational): inputs value, 2-bit digit, weight, mode; output is the shifted value. One instance is shared by all three stages, with the weight selected by state.
- The base-3 digit split is inline combinational logic on shamt, registered on accept.

## Test plan
- SLL, data_in=0x0001, shamt=5 (digits 2,1,0) -> result=0x0020; done 3 cycles after accept; busy high for exactly 3 cycles.
- SRA, data_in=0x8000, shamt=15 (digits 0,2,1) -> result=0xFFFF. SRA, 0x7F00, shamt=8 -> 0x007F.
- ROR, data_in=0x1234, shamt=4 -> 0x4123. ROR, 0x0001, shamt=9 -> 0x0080. shamt=0 in any mode -> result=data_in, latency still 3.
- start pulsed during THREES with different data -> ignored; result matches the first request only. start held high in DONE -> second request accepted; its done arrives 4 cycles after the first done.
- rst_n driven low for one cycle while in THREES -> busy=0, done=0, result=0 immediately; no done pulse follows; the next request completes normally.
- Exhaustive: all 4 modes × shamt 0..15 × random data_in compared against a reference shift; done is never asserted for two consecutive cycles.
